// File: rtl/l2_arb_pkg.sv
// Shared types and defaults for the L2 line-port arbiter.
// The arbitration policy macro ARB_ROUND_ROBIN_EN is consumed in l2_arb_pick.
package l2_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned LINE_W_DEF = 256;
    localparam int unsigned BE_W_DEF   = LINE_W_DEF / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    function automatic requester_t other_side(input requester_t r);
        return (r == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational winner selection between the I-side and D-side line requests.
// ARB_ROUND_ROBIN_EN: defined -> alternate on contention; undefined -> D always beats I.
module l2_arb_pick
    import l2_arb_pkg::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  requester_t i_last_grant,
    output logic       o_any,
    output requester_t o_winner
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        o_any    = i_req_i | i_req_d;
        o_winner = REQ_D;
        if (i_req_i && i_req_d) begin
            o_winner = other_side(i_last_grant);
        end else if (i_req_i) begin
            o_winner = REQ_I;
        end
    end
`else
    // History is still tracked by the top; fixed priority simply ignores it.
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;

    always_comb begin
        o_any    = i_req_i | i_req_d;
        o_winner = REQ_D;
        if (i_req_i && !i_req_d) begin
            o_winner = REQ_I;
        end
    end
`endif

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 line port between the L1 I-miss and D-miss paths, one transaction at a time.
// Arbitration policy selected by ARB_ROUND_ROBIN_EN (see l2_arb_pick); default is fixed D-over-I.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LINE_W = LINE_W_DEF,
    parameter int unsigned BE_W   = BE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic [ADDR_W-1:0] l2_address,
    output logic              l2_read,
    output logic              l2_write,
    output logic [LINE_W-1:0] l2_wdata,
    output logic [BE_W-1:0]   l2_byte_enable,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    arb_state_t r_state;
    requester_t r_last_grant;

    logic       w_any;
    requester_t w_winner;
    logic       w_gnt_i;
    logic       w_gnt_d;

    l2_arb_pick u_pick (
        .i_req_i      (i_read),
        .i_req_d      (d_read | d_write),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_winner     (w_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_I;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= (w_winner == REQ_D) ? GNT_D : GNT_I;
                    end
                end
                GNT_I: begin
                    if (l2_resp) begin
                        r_state      <= DONE;
                        r_last_grant <= REQ_I;
                    end
                end
                GNT_D: begin
                    if (l2_resp) begin
                        r_state      <= DONE;
                        r_last_grant <= REQ_D;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_gnt_i = (r_state == GNT_I);
    assign w_gnt_d = (r_state == GNT_D);

    // Everything below is decoded from the state, so an async reset drops the strobes at once.
    always_comb begin
        l2_address     = '0;
        l2_read        = 1'b0;
        l2_write       = 1'b0;
        l2_wdata       = '0;
        l2_byte_enable = '0;
        if (w_gnt_d) begin
            l2_address     = d_address;
            l2_read        = d_read & ~d_write;
            l2_write       = d_write;
            l2_wdata       = d_wdata;
            l2_byte_enable = '1;
        end else if (w_gnt_i) begin
            l2_address     = i_address;
            l2_read        = 1'b1;
            l2_byte_enable = '1;
        end
    end

    assign i_rdata = w_gnt_i ? l2_rdata : '0;
    assign d_rdata = w_gnt_d ? l2_rdata : '0;
    assign i_resp  = w_gnt_i & l2_resp;
    assign d_resp  = w_gnt_d & l2_resp;

endmodule
